instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage that sits directly upstream of the single-cycle control decoder.
- Owns the program counter and issues word reads to instruction memory over a valid/ready request plus a response-valid return.
- Holds each fetched 32-bit instruction and presents it, together with its 11-bit opcode field (instr[31:21]), to decode/control.
- Applies PC redirects (taken CBZ, B) from the execute stage.

Parameters:
- ADDR_W, 64: PC and memory address width.
- RESET_PC, 0: PC value loaded on reset.
- MAX_WAIT, 15: response-wait cycles before fetch_timeout is raised.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- resetl  in  1  synchronous, active-low reset; sampled on rising CLK.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  ADDR_W  request address; equals the PC while imem_req_valid=1.
- imem_rsp_valid  in  1  response data valid; single-cycle pulse.
- imem_rsp_data  in  32  instruction word.
- instr_valid  out  1  held instruction valid to decode.
- instr_ready  in  1  decode/execute consumes the instruction this cycle.
- instr  out  32  held instruction.
- opcode  out  11  instr[31:21]; control decoder input.
- instr_pc  out  ADDR_W  address of the held instruction.
- redirect  in  1  branch taken; load redirect_pc.
- redirect_pc  in  ADDR_W  branch target.
- fetch_timeout  out  1  sticky error flag.

Behaviour:
- Reset (resetl=0 at a rising edge):
  - pc=RESET_PC, state=IDLE, wait counter=0.
  - instr=0, instr_pc=0, fetch_timeout=0.
  - Outputs while in reset: imem_req_valid=0, instr_valid=0. opcode follows instr, so it reads 0.
  - Reset asserted mid-operation (any state) aborts the operation. A memory response arriving in the cycle after reset is ignored.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE:
  - Outputs all inactive.
  - Next cycle goes to REQ unconditionally.
- REQ:
  - imem_req_valid=1, imem_addr=pc.
  - On imem_req_ready=1, go to WAIT and clear the counter.
- WAIT:
  - Counter increments each cycle that imem_rsp_valid=0. It saturates at MAX_WAIT.
  - When the counter equals MAX_WAIT, set fetch_timeout=1 (sticky until reset) and keep waiting.
  - On imem_rsp_valid=1: instr<=imem_rsp_data, instr_pc<=pc, go to HOLD.
  - Minimum latency from request acceptance to instr_valid is 2 cycles: response in the cycle after acceptance, registered one edge later.
- HOLD:
  - instr_valid=1. instr, opcode and instr_pc are stable.
  - On instr_ready=1: pc<=pc+4 (modulo 2^ADDR_W, wraps silently), go to REQ.
- Redirect (highest priority, any state except reset):
  - pc<=redirect_pc. instr_valid deasserts the next cycle.
  - From IDLE, REQ or HOLD: go to REQ. A request handshake completing in the same cycle as redirect is treated as in-flight, so go to DRAIN instead.
  - From WAIT with no imem_rsp_valid this cycle: go to DRAIN.
  - From WAIT with imem_rsp_valid this cycle: discard the data and go to REQ.
  - redirect together with instr_ready in HOLD: redirect wins; no +4.
- DRAIN:
  - imem_req_valid=0. Wait for imem_rsp_valid and discard the data, then go to REQ.
  - A further redirect in DRAIN updates pc and stays in DRAIN.
- Only one request is outstanding at any time.
- imem_addr is 0 whenever imem_req_valid=0.
- The block checks no alignment; redirect_pc is used verbatim.

Decomposition:
- Shared package (fetch_pkg):
  - State enum: IDLE, REQ, WAIT, HOLD, DRAIN.
  - Constants: INSTR_W=32, OPCODE_MSB=31, OPCODE_LSB=21, PC_INC=4.
  - The control decoder uses the same OPCODE field constants.
- One natural sub-module, fetch_pc_reg:
  - Contains the PC register with reset value, +4 increment and redirect mux.
  - Controlled by the FSM via inc/load strobes.

Test Plan:
- Reset then zero-wait memory returning 0xF84003E9 at addr 0:
  - imem_addr=0 in the first REQ cycle.
  - instr_valid=1 with opcode=11'h7C2 and instr_pc=0 two cycles after acceptance.
  - After instr_ready, the next request goes to addr 4.
- Memory with 3-cycle response latency and instr_ready held low for 5 cycles:
  - instr and opcode stay stable throughout the hold.
  - No second request is issued until instr_ready=1.
- Redirect to 0x40 while in WAIT:
  - Memory returns 0xDEADBEEF later; it is discarded and instr_valid stays 0.
  - The next request is to 0x40.
- Redirect to 0x100 in the same cycle as instr_ready in HOLD:
  - The next request is to 0x100, not pc+4.
- Response withheld for 20 cycles:
  - fetch_timeout rises after 15 wait cycles and remains 1.
  - The late response is still accepted.
  - Only resetl=0 clears the flag.
- resetl pulsed low during WAIT, with the response arriving on the following cycle:
  - The response is ignored.
  - pc=RESET_PC, fetch_timeout=0.
  - The fetch restarts at 0 via IDLE→REQ.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and instruction-field constants for the fetch stage and the
// control decoder that consumes its opcode output.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_e;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 21;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int PC_INC     = 4;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset value, sequential +4 advance and branch-target load.
// A load always takes priority over an increment in the same cycle.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // NOTE: pc_d gets a default before any branch so no path leaves it unassigned and infers a latch.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_pc;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(PC_INC);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues one word read at a time, holds the returned instruction
// for decode and follows branch redirects from execute.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 15
) (
  input  logic                CLK,
  input  logic                resetl,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [INSTR_W-1:0]  imem_rsp_data,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   instr_pc,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                fetch_timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  fetch_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               timeout_q, timeout_d;
  logic               pc_inc;
  logic [ADDR_W-1:0]  pc;

  fetch_pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .CLK    (CLK),
    .resetl (resetl),
    .inc    (pc_inc),
    .load   (redirect),
    .load_pc(redirect_pc),
    .pc     (pc)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    timeout_d  = timeout_q;
    pc_inc     = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req_ready) begin
          // An accepted request is in flight even if we were redirected.
          state_d = redirect ? DRAIN : WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_d = redirect ? REQ : HOLD;
          if (!redirect) begin
            instr_d    = imem_rsp_data;
            instr_pc_d = pc;
          end
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) timeout_d = 1'b1;
          if (redirect) state_d = DRAIN;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_d = REQ;
        end else if (instr_ready) begin
          pc_inc  = 1'b1;
          state_d = REQ;
        end
      end
      DRAIN: if (imem_rsp_valid) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (redirect && state_q inside {IDLE, HOLD}) state_d = REQ;
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      timeout_q  <= timeout_d;
    end
  end

  // Handshake outputs are forced low during the reset cycle itself.
  assign imem_req_valid = resetl && (state_q == REQ);
  assign imem_addr      = imem_req_valid ? pc : '0;
  assign instr_valid    = resetl && (state_q == HOLD);
  assign instr          = instr_q;
  assign opcode         = opcode_of(instr_q);
  assign instr_pc       = instr_pc_q;
  assign fetch_timeout  = timeout_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized traffic, all compared against a behavioural fetch model.
module tb_instruction_fetch;

  localparam int          ADDR_W   = 64;
  localparam int          MAX_WAIT = 15;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [10:0] opcode;
  logic [63:0] instr_pc;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        fetch_timeout;

  always #5 CLK = ~CLK;

  instruction_fetch #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .CLK           (CLK),
    .resetl        (resetl),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .opcode        (opcode),
    .instr_pc      (instr_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .fetch_timeout (fetch_timeout)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      if (n_fails <= 40) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Staged stimulus, applied at the next falling edge.
  logic        s_resetl = 1'b0, s_req_ready = 1'b0, s_instr_ready = 1'b0, s_redirect = 1'b0;
  logic [63:0] s_rpc = '0;
  int          mem_lat = 1;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_data = '0;
  logic        chk_en = 1'b0;

  // Memory: one pending request, answered mem_lat cycles after acceptance.
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hF84003E9 ^ (a[31:0] * 32'h9E3779B1) ^ a[63:32];
  endfunction

  // Behavioural model: a request is either not yet issued, outstanding
  // (possibly to be dropped), or its instruction is being held for decode.
  logic        m_idle, m_valid, m_out, m_drop, m_to;
  int          m_cnt;
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_instr;

  task automatic model_step();
    if (!resetl) begin
      m_pc = RESET_PC; m_idle = 1'b1; m_valid = 1'b0; m_out = 1'b0; m_drop = 1'b0;
      m_cnt = 0; m_to = 1'b0; m_instr = '0; m_ipc = '0;
    end else if (m_idle) begin
      m_idle = 1'b0;
      if (redirect) m_pc = redirect_pc;
    end else if (m_valid) begin
      if (redirect) begin
        m_pc = redirect_pc; m_valid = 1'b0;
      end else if (instr_ready) begin
        m_pc = m_pc + 64'd4; m_valid = 1'b0;
      end
    end else if (!m_out) begin
      if (imem_req_ready) begin
        m_out = 1'b1; m_drop = redirect; m_cnt = 0;
      end
      if (redirect) m_pc = redirect_pc;
    end else if (!m_drop) begin
      if (imem_rsp_valid) begin
        m_out = 1'b0;
        if (!redirect) begin
          m_valid = 1'b1; m_instr = imem_rsp_data; m_ipc = m_pc;
        end
      end else begin
        if (m_cnt < MAX_WAIT) m_cnt++;
        if (m_cnt == MAX_WAIT) m_to = 1'b1;
        if (redirect) m_drop = 1'b1;
      end
      if (redirect) m_pc = redirect_pc;
    end else begin
      if (imem_rsp_valid) begin
        m_out = 1'b0; m_drop = 1'b0;
      end
      if (redirect) m_pc = redirect_pc;
    end
  endtask

  task automatic compare();
    logic exp_rv;
    exp_rv = resetl && !m_idle && !m_valid && !m_out;
    check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    check("imem_addr", imem_addr, exp_rv ? m_pc : 64'h0);
    check("instr_valid", 64'(instr_valid), 64'(resetl && m_valid));
    check("instr", 64'(instr), 64'(m_instr));
    check("opcode", 64'(opcode), 64'(m_instr[31:21]));
    check("instr_pc", instr_pc, m_ipc);
    check("fetch_timeout", 64'(fetch_timeout), 64'(m_to));
  endtask

  // One clock: drive at the falling edge, compare, then advance model and memory.
  task automatic cyc();
    logic        rv, hs;
    logic [63:0] hs_addr;
    @(negedge CLK);
    rv             = mem_pend && (mem_cnt == 1);
    resetl         = s_resetl;
    imem_req_ready = s_req_ready;
    instr_ready    = s_instr_ready;
    redirect       = s_redirect;
    redirect_pc    = s_rpc;
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? (ovr_en ? ovr_data : mem_word(mem_addr)) : $urandom();
    #1;
    if (chk_en) compare();
    hs      = imem_req_valid && imem_req_ready;
    hs_addr = imem_addr;
    @(posedge CLK);
    model_step();
    if (rv) mem_pend = 1'b0;
    else if (mem_pend && mem_cnt > 1) mem_cnt--;
    if (hs) begin
      mem_pend = 1'b1; mem_cnt = mem_lat; mem_addr = hs_addr;
    end
  endtask

  initial begin
    logic [31:0] w4;
    resetl = 1'b0; imem_req_ready = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    // Reset, then zero-wait memory returning 0xF84003E9 at address 0.
    cyc();
    chk_en = 1'b1;
    cyc();
    #1;
    check("rst_req_valid", 64'(imem_req_valid), 64'h0);
    check("rst_instr_valid", 64'(instr_valid), 64'h0);
    check("rst_opcode", 64'(opcode), 64'h0);
    check("rst_timeout", 64'(fetch_timeout), 64'h0);
    s_resetl = 1'b1; s_req_ready = 1'b1; mem_lat = 1;
    cyc();
    #1;
    check("first_req_valid", 64'(imem_req_valid), 64'h1);
    check("first_addr", imem_addr, 64'h0);
    cyc();
    cyc();
    #1;
    check("t1_instr_valid", 64'(instr_valid), 64'h1);
    check("t1_instr", 64'(instr), 64'hF84003E9);
    check("t1_opcode", 64'(opcode), 64'h7C2);
    check("t1_instr_pc", instr_pc, 64'h0);
    s_instr_ready = 1'b1;
    cyc();
    s_instr_ready = 1'b0;
    #1;
    check("t1_next_addr", imem_addr, 64'h4);

    // Three-cycle latency, decode stalled for five cycles.
    mem_lat = 3;
    w4 = mem_word(64'h4);
    repeat (4) cyc();
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t2_hold_valid", 64'(instr_valid), 64'h1);
      check("t2_hold_instr", 64'(instr), 64'(w4));
      check("t2_hold_opcode", 64'(opcode), 64'(w4[31:21]));
      check("t2_no_req", 64'(imem_req_valid), 64'h0);
      if (i < 5) cyc();
    end
    s_instr_ready = 1'b1;
    cyc();
    s_instr_ready = 1'b0;
    #1;
    check("t2_next_addr", imem_addr, 64'h8);

    // Redirect to 0x40 while waiting; late 0xDEADBEEF is discarded.
    cyc();
    s_redirect = 1'b1; s_rpc = 64'h40; ovr_en = 1'b1; ovr_data = 32'hDEADBEEF;
    cyc();
    s_redirect = 1'b0;
    cyc();
    #1;
    check("t3_drain_valid", 64'(instr_valid), 64'h0);
    check("t3_drain_no_req", 64'(imem_req_valid), 64'h0);
    cyc();
    ovr_en = 1'b0;
    #1;
    check("t3_after_valid", 64'(instr_valid), 64'h0);
    check("t3_redir_addr", imem_addr, 64'h40);

    // Redirect to 0x100 together with instr_ready in HOLD.
    mem_lat = 1;
    cyc();
    cyc();
    #1;
    check("t4_instr_pc", instr_pc, 64'h40);
    s_instr_ready = 1'b1; s_redirect = 1'b1; s_rpc = 64'h100;
    cyc();
    s_instr_ready = 1'b0; s_redirect = 1'b0;
    #1;
    check("t4_redir_addr", imem_addr, 64'h100);
    check("t4_valid_drop", 64'(instr_valid), 64'h0);

    // Response withheld for 20 cycles.
    mem_lat = 21;
    cyc();
    for (int i = 1; i <= 20; i++) begin
      cyc();
      #1;
      if (i == 14) check("t5_timeout_early", 64'(fetch_timeout), 64'h0);
      if (i == 15) check("t5_timeout_rise", 64'(fetch_timeout), 64'h1);
    end
    cyc();
    #1;
    check("t5_late_valid", 64'(instr_valid), 64'h1);
    check("t5_late_pc", instr_pc, 64'h100);
    s_instr_ready = 1'b1;
    cyc();
    s_instr_ready = 1'b0;
    #1;
    check("t5_timeout_sticky", 64'(fetch_timeout), 64'h1);
    check("t5_next_addr", imem_addr, 64'h104);

    // Reset during WAIT with the response arriving one cycle later.
    mem_lat = 2;
    cyc();
    s_resetl = 1'b0;
    cyc();
    #1;
    check("t6_timeout_clr", 64'(fetch_timeout), 64'h0);
    s_resetl = 1'b1;
    cyc();
    #1;
    check("t6_restart_req", 64'(imem_req_valid), 64'h1);
    check("t6_restart_addr", imem_addr, RESET_PC);
    check("t6_no_instr", 64'(instr_valid), 64'h0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      s_resetl      = ($urandom_range(99) != 0);
      s_req_ready   = ($urandom_range(9) < 7);
      s_instr_ready = $urandom_range(1);
      s_redirect    = ($urandom_range(19) == 0);
      if ($urandom_range(3) == 0) s_rpc = {32'hFFFFFFFF, 32'hFFFFFFF0 | 32'($urandom_range(15))};
      else s_rpc = {$urandom(), $urandom()};
      mem_lat = ($urandom_range(29) == 0) ? $urandom_range(20, 17) : $urandom_range(4, 1);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
